butt_serializer: RTL and testbench

BUTT_SERIALIZER -- requirements
Module: butt_serializer

---
 rtl/butt_serializer_if.sv | 7 +
 rtl/butt_serializer.sv | 61 ++++++
 tb/tb_butt_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/butt_serializer_if.sv
// butt_serializer_if: butterfly-pair input and serial-sample output handshakes
interface butt_serializer_if #(parameter int IN_W = 11);
  logic i_vld, o_rdy, o_vld, i_rdy, o_last;
  logic signed [IN_W-1:0] i_LI, i_LQ, i_RI, i_RQ, o_I, o_Q;
  modport master(output i_vld, i_LI, i_LQ, i_RI, i_RQ, i_rdy, input o_rdy, o_vld, o_I, o_Q, o_last);
  modport slave(input i_vld, i_LI, i_LQ, i_RI, i_RQ, i_rdy, output o_rdy, o_vld, o_I, o_Q, o_last);
endinterface

// File: rtl/butt_serializer.sv
// butt_serializer: turns HALF butterfly L/R pairs into L0..L(HALF-1), R0..R(HALF-1)
module butt_serializer #(
  parameter int IN_W = 11,
  parameter int STAGE = 0,
  parameter int TOTAL_STAGES = 8
) (
  input logic mclk,
  input logic i_rst_n,
  input logic i_init,
  butt_serializer_if.slave bus
);
  localparam int HALF = 2 ** (TOTAL_STAGES - STAGE - 1);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);
  typedef enum logic {ST_L, ST_R} state_t;
  state_t st;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [2*IN_W-1:0] buf_mem [2**CW];
  logic ld, acc, wr_last, rd_last;
  assign ld = ~bus.o_vld | bus.i_rdy;
  assign bus.o_rdy = i_rst_n & (st == ST_L) & ld;
  assign acc = bus.i_vld & bus.o_rdy;
  assign wr_last = wr_cnt == LAST;
  assign rd_last = rd_cnt == LAST;
  // R half of every pair parks here until all L samples have gone out
  always_ff @(posedge mclk)
    if (acc) buf_mem[wr_cnt] <= {bus.i_RI, bus.i_RQ};
  always_ff @(posedge mclk or negedge i_rst_n)
    if (!i_rst_n) begin
      st <= ST_L;
      wr_cnt <= '0;
      rd_cnt <= '0;
      bus.o_vld <= 1'b0;
      bus.o_last <= 1'b0;
      bus.o_I <= '0;
      bus.o_Q <= '0;
    end else if (i_init) begin
      st <= ST_L;
      wr_cnt <= '0;
      rd_cnt <= '0;
      bus.o_vld <= 1'b0;
      bus.o_last <= 1'b0;
    end else if (ld) begin
      if (st == ST_L) begin
        bus.o_vld <= bus.i_vld;
        bus.o_last <= 1'b0;
        if (bus.i_vld) begin
          bus.o_I <= bus.i_LI;
          bus.o_Q <= bus.i_LQ;
          wr_cnt <= wr_last ? '0 : wr_cnt + CW'(1);
          st <= wr_last ? ST_R : ST_L;
        end
      end else begin
        bus.o_vld <= 1'b1;
        {bus.o_I, bus.o_Q} <= buf_mem[rd_cnt];
        bus.o_last <= rd_last;
        rd_cnt <= rd_last ? '0 : rd_cnt + CW'(1);
        st <= rd_last ? ST_L : ST_R;
      end
    end
endmodule

// File: tb/tb_butt_serializer.sv
// tb_butt_serializer: queue-model checked bench for HALF=4 and HALF=1 serializers
module tb_butt_serializer;
  typedef struct {int i; int q; bit last; bit is_r;} item_t;
  logic mclk = 0, rst_n = 0, init = 0;
  bit bp_en = 0;
  int cyc = 0, errors = 0, checks = 0;
  int half[2] = '{4, 1};
  item_t expq[2][$];
  item_t pend[2][$];
  int log_i[2][$];
  int log_last[2][$];
  int exp_i[$];
  int exp_l[$];
  butt_serializer_if #(.IN_W(11)) b0();
  butt_serializer_if #(.IN_W(8)) b1();
  butt_serializer #(.IN_W(11), .STAGE(0), .TOTAL_STAGES(3)) dut0(.mclk(mclk), .i_rst_n(rst_n), .i_init(init), .bus(b0));
  butt_serializer #(.IN_W(8), .STAGE(2), .TOTAL_STAGES(3)) dut1(.mclk(mclk), .i_rst_n(rst_n), .i_init(init), .bus(b1));
  always #5 mclk = ~mclk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask
  // Model: L goes straight to the expected stream, R waits until a full block of pairs is in
  task automatic check_side(input int s, input bit in_init, input bit vld, input bit ordy,
                            input int li, input int lq, input int ri, input int rq,
                            input bit ovld, input bit irdy, input int oi, input int oq, input bit olast);
    int unl;
    int n;
    item_t it;
    if (!rst_n) begin
      chk($sformatf("s%0d_rdy_in_reset", s), int'(ordy), 0);
      expq[s].delete();
      pend[s].delete();
      return;
    end
    unl = 0;
    for (int k = 0; k < expq[s].size(); k++) if (expq[s][k].is_r) unl++;
    if (ovld && expq[s].size() > 0 && expq[s][0].is_r) unl--;
    chk($sformatf("s%0d_o_rdy", s), int'(ordy), int'(unl == 0 && (!ovld || irdy)));
    if (ovld && irdy) begin
      if (expq[s].size() == 0) chk($sformatf("s%0d_unexpected_sample_I", s), oi, -9999);
      else begin
        it = expq[s].pop_front();
        chk($sformatf("s%0d_o_I", s), oi, it.i);
        chk($sformatf("s%0d_o_Q", s), oq, it.q);
        chk($sformatf("s%0d_o_last", s), int'(olast), int'(it.last));
      end
      log_i[s].push_back(oi);
      log_last[s].push_back(int'(olast));
    end
    if (in_init) begin
      expq[s].delete();
      pend[s].delete();
    end else if (vld && ordy) begin
      expq[s].push_back('{li, lq, 1'b0, 1'b0});
      pend[s].push_back('{ri, rq, 1'b0, 1'b1});
      if (pend[s].size() == half[s]) begin
        n = pend[s].size();
        for (int k = 0; k < n; k++) begin
          it = pend[s][k];
          it.last = (k == n - 1);
          expq[s].push_back(it);
        end
        pend[s].delete();
      end
    end
  endtask
  always @(negedge mclk) begin
    check_side(0, init, b0.i_vld, b0.o_rdy, int'(b0.i_LI), int'(b0.i_LQ), int'(b0.i_RI), int'(b0.i_RQ),
               b0.o_vld, b0.i_rdy, int'(b0.o_I), int'(b0.o_Q), b0.o_last);
    check_side(1, init, b1.i_vld, b1.o_rdy, int'(b1.i_LI), int'(b1.i_LQ), int'(b1.i_RI), int'(b1.i_RQ),
               b1.o_vld, b1.i_rdy, int'(b1.o_I), int'(b1.o_Q), b1.o_last);
  end
  always @(posedge mclk) begin
    cyc++;
    #1;
    b0.i_rdy = !(bp_en && cyc % 3 == 0);
    b1.i_rdy = b0.i_rdy;
  end
  task automatic feed(input int s, input int li, input int lq, input int ri, input int rq);
    bit acc;
    if (s == 0) begin
      b0.i_vld = 1; b0.i_LI = 11'(li); b0.i_LQ = 11'(lq); b0.i_RI = 11'(ri); b0.i_RQ = 11'(rq);
    end else begin
      b1.i_vld = 1; b1.i_LI = 8'(li); b1.i_LQ = 8'(lq); b1.i_RI = 8'(ri); b1.i_RQ = 8'(rq);
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge mclk);
      acc = (s == 0) ? b0.o_rdy : b1.o_rdy;
      @(posedge mclk);
      #1;
      if (acc) break;
      if (n == 49) chk("accept_timeout", 0, 1);
    end
    b0.i_vld = 0;
    b1.i_vld = 0;
    @(posedge mclk);
    #1;
  endtask
  task automatic wait_idle(input int s);
    for (int n = 0; n < 100 && (expq[s].size() != 0 || pend[s].size() != 0); n++) begin
      @(posedge mclk);
      #1;
    end
    chk("drain_timeout", expq[s].size() + pend[s].size(), 0);
    @(posedge mclk);
    #1;
  endtask
  task automatic check_log(input int s, input string tag);
    chk({tag, "_len"}, log_i[s].size(), exp_i.size());
    for (int k = 0; k < exp_i.size() && k < log_i[s].size(); k++) begin
      chk($sformatf("%s_I%0d", tag, k), log_i[s][k], exp_i[k]);
      chk($sformatf("%s_last%0d", tag, k), log_last[s][k], exp_l[k]);
    end
    log_i[s].delete();
    log_last[s].delete();
  endtask
  task automatic run_block(input int bl, input int br);
    for (int k = 0; k < 4; k++) feed(0, bl + k, -(bl + k), br + k, -(br + k));
    wait_idle(0);
  endtask
  initial begin
    #600000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1);
  end
  initial begin
    b0.i_vld = 0; b0.i_rdy = 1; b0.i_LI = 0; b0.i_LQ = 0; b0.i_RI = 0; b0.i_RQ = 0;
    b1.i_vld = 0; b1.i_rdy = 1; b1.i_LI = 0; b1.i_LQ = 0; b1.i_RI = 0; b1.i_RQ = 0;
    #12;
    chk("reset_o_vld", int'(b0.o_vld), 0);
    chk("reset_o_last", int'(b0.o_last), 0);
    chk("reset_o_I", int'(b0.o_I), 0);
    chk("reset_o_Q", int'(b0.o_Q), 0);
    chk("reset_o_rdy", int'(b0.o_rdy), 0);
    @(posedge mclk);
    #1 rst_n = 1;
    #2 chk("release_o_rdy", int'(b0.o_rdy), 1);
    @(posedge mclk);
    #1;
    run_block(0, 10);
    exp_i = '{0, 1, 2, 3, 10, 11, 12, 13};
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
    check_log(0, "stream");
    bp_en = 1;
    run_block(0, 10);
    check_log(0, "backpressure");
    bp_en = 0;
    feed(0, 0, 0, 10, -10);
    feed(0, 1, -1, 11, -11);
    init = 1;
    @(posedge mclk);
    #1 init = 0;
    chk("abort_o_vld", int'(b0.o_vld), 0);
    log_i[0].delete();
    log_last[0].delete();
    run_block(20, 30);
    exp_i = '{20, 21, 22, 23, 30, 31, 32, 33};
    check_log(0, "abort_fresh");
    for (int k = 0; k < 4; k++) feed(0, 40 + k, -(40 + k), 50 + k, -(50 + k));
    #2 rst_n = 0;
    #1;
    chk("async_o_vld", int'(b0.o_vld), 0);
    chk("async_o_last", int'(b0.o_last), 0);
    repeat (2) @(posedge mclk);
    #3 rst_n = 1;
    #2 chk("async_release_o_rdy", int'(b0.o_rdy), 1);
    @(posedge mclk);
    #1;
    log_i[0].delete();
    log_last[0].delete();
    run_block(80, 90);
    exp_i = '{80, 81, 82, 83, 90, 91, 92, 93};
    check_log(0, "after_reset");
    feed(1, 5, 3, -5, -3);
    feed(1, -128, 100, 127, -100);
    wait_idle(1);
    exp_i = '{5, -5, -128, 127};
    exp_l = '{0, 1, 0, 1};
    check_log(1, "half1");
    for (int k = 0; k < 3; k++) feed(0, 60 + k, -(60 + k), 65 + k, -(65 + k));
    log_i[0].delete();
    log_last[0].delete();
    b0.i_vld = 1; b0.i_LI = 11'(63); b0.i_LQ = 11'(-63); b0.i_RI = 11'(68); b0.i_RQ = 11'(-68);
    init = 1;
    #2 chk("simul_o_rdy", int'(b0.o_rdy), 1);
    @(posedge mclk);
    #1 init = 0;
    b0.i_vld = 0;
    chk("simul_o_vld", int'(b0.o_vld), 0);
    repeat (6) @(posedge mclk);
    #1 chk("simul_no_r_emitted", log_i[0].size(), 0);
    run_block(70, 75);
    exp_i = '{70, 71, 72, 73, 75, 76, 77, 78};
    exp_l = '{0, 0, 0, 0, 0, 0, 0, 1};
    check_log(0, "simul_fresh");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
